// File: rtl/edge_gen_pkg.sv
// Shared types and helpers for the edge generator: FSM state encoding and
// the half-period timer width calculation.
package edge_gen_pkg;

  typedef enum logic [1:0] {
    EG_IDLE   = 2'd0,
    EG_ACTIVE = 2'd1,
    EG_REST   = 2'd2
  } eg_state_t;

  function automatic int unsigned eg_timer_width(input int unsigned half_period);
    return (half_period < 1) ? 1 : $clog2(half_period + 1);
  endfunction

endpackage

// File: rtl/edge_gen_timer.sv
// Loadable half-period down-counter; expired is high while enabled and the
// count has reached zero.
module edge_gen_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = en && (count == '0);

endmodule

// File: rtl/edge_gen.sv
// Edge generator: emits a burst of N square-wave periods with a programmable
// half period. Optional abort input enabled by defining EDGE_GEN_ABORT_EN.
module edge_gen
  import edge_gen_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter logic        IDLE_LEVEL  = 1'b0
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_cycles,
`ifdef EDGE_GEN_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 sig_out,
  output logic                 lead_edge,
  output logic                 trail_edge,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned      TW      = eg_timer_width(HALF_PERIOD);
  localparam logic [TW-1:0]    HALF_M1 = TW'(HALF_PERIOD - 1);

  eg_state_t            state;
  logic [CNT_WIDTH-1:0] remaining;
  logic                 tmr_load;
  logic                 tmr_expired;
  logic                 abort_hit;

`ifdef EDGE_GEN_ABORT_EN
  assign abort_hit = abort && (state != EG_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Timer reload mirrors every transition into ACTIVE or REST so each half
  // period starts from a fresh count.
  always_comb begin
    tmr_load = 1'b0;
    case (state)
      EG_IDLE:   tmr_load = start && (num_cycles != '0);
      EG_ACTIVE: tmr_load = tmr_expired;
      EG_REST:   tmr_load = tmr_expired && (remaining != '0);
      default:   tmr_load = 1'b0;
    endcase
  end

  edge_gen_timer #(
    .WIDTH (TW)
  ) u_timer (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .en       (state != EG_IDLE),
    .load     (tmr_load),
    .load_val (HALF_M1),
    .expired  (tmr_expired)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EG_IDLE;
      remaining  <= '0;
      sig_out    <= IDLE_LEVEL;
      lead_edge  <= 1'b0;
      trail_edge <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      lead_edge  <= 1'b0;
      trail_edge <= 1'b0;
      done       <= 1'b0;
      if (abort_hit) begin
        state      <= EG_IDLE;
        remaining  <= '0;
        sig_out    <= IDLE_LEVEL;
        trail_edge <= (state == EG_ACTIVE);
        busy       <= 1'b0;
        done       <= 1'b1;
      end else begin
        case (state)
          EG_IDLE: begin
            if (start) begin
              if (num_cycles != '0) begin
                remaining <= num_cycles;
                state     <= EG_ACTIVE;
                sig_out   <= ~IDLE_LEVEL;
                lead_edge <= 1'b1;
                busy      <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          EG_ACTIVE: begin
            if (tmr_expired) begin
              state      <= EG_REST;
              sig_out    <= IDLE_LEVEL;
              trail_edge <= 1'b1;
              if (remaining != '0) remaining <= remaining - 1'b1;
            end
          end
          EG_REST: begin
            if (tmr_expired) begin
              if (remaining != '0) begin
                state     <= EG_ACTIVE;
                sig_out   <= ~IDLE_LEVEL;
                lead_edge <= 1'b1;
              end else begin
                state <= EG_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: state <= EG_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_edge_gen.sv
// Directed bench for edge_gen: two instances (H=4 idle-low, H=1 idle-high)
// driven from a run-length vector table plus reset and abort sequences.
module tb_edge_gen;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] num_a   = '0,   num_b   = '0;
  logic       abort_a = 1'b0;
  logic       sig_a, lead_a, trail_a, busy_a, done_a;
  logic       sig_b, lead_b, trail_b, busy_b, done_b;
  logic [4:0] obs_a, obs_b;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  edge_gen #(.HALF_PERIOD(4), .CNT_WIDTH(8), .IDLE_LEVEL(1'b0)) dut_a (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .start      (start_a),
    .num_cycles (num_a),
`ifdef EDGE_GEN_ABORT_EN
    .abort      (abort_a),
`endif
    .sig_out    (sig_a),
    .lead_edge  (lead_a),
    .trail_edge (trail_a),
    .busy       (busy_a),
    .done       (done_a)
  );

  edge_gen #(.HALF_PERIOD(1), .CNT_WIDTH(8), .IDLE_LEVEL(1'b1)) dut_b (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .start      (start_b),
    .num_cycles (num_b),
`ifdef EDGE_GEN_ABORT_EN
    .abort      (1'b0),
`endif
    .sig_out    (sig_b),
    .lead_edge  (lead_b),
    .trail_edge (trail_b),
    .busy       (busy_b),
    .done       (done_b)
  );

  // Observed outputs packed as {sig_out, lead_edge, trail_edge, busy, done}.
  assign obs_a = {sig_a, lead_a, trail_a, busy_a, done_a};
  assign obs_b = {sig_b, lead_b, trail_b, busy_b, done_b};

  typedef struct {
    int unsigned dut;
    int unsigned reps;
    logic        start;
    logic [7:0]  num;
    logic [4:0]  exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int unsigned dut, input int unsigned reps,
                     input logic start, input logic [7:0] num, input logic [4:0] exp);
    vec_t v;
    v.dut = dut; v.reps = reps; v.start = start; v.num = num; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int done_cnt;
    int trail_cnt;

    // Burst A: H=4, N=3, a start ignored while busy, back-to-back start in done cycle.
    add(0, 1, 1'b1, 8'd3, 5'b00000);
    add(0, 1, 1'b0, 8'd0, 5'b11010);
    add(0, 1, 1'b1, 8'd7, 5'b10010);
    add(0, 2, 1'b0, 8'd0, 5'b10010);
    add(0, 1, 1'b0, 8'd0, 5'b00110);
    add(0, 3, 1'b0, 8'd0, 5'b00010);
    add(0, 1, 1'b0, 8'd0, 5'b11010);
    add(0, 3, 1'b0, 8'd0, 5'b10010);
    add(0, 1, 1'b0, 8'd0, 5'b00110);
    add(0, 3, 1'b0, 8'd0, 5'b00010);
    add(0, 1, 1'b0, 8'd0, 5'b11010);
    add(0, 3, 1'b0, 8'd0, 5'b10010);
    add(0, 1, 1'b0, 8'd0, 5'b00110);
    add(0, 3, 1'b0, 8'd0, 5'b00010);
    add(0, 1, 1'b1, 8'd1, 5'b00001);
    add(0, 1, 1'b0, 8'd0, 5'b11010);
    add(0, 3, 1'b0, 8'd0, 5'b10010);
    add(0, 1, 1'b0, 8'd0, 5'b00110);
    add(0, 3, 1'b0, 8'd0, 5'b00010);
    add(0, 1, 1'b0, 8'd0, 5'b00001);
    add(0, 1, 1'b0, 8'd0, 5'b00000);
    // Zero-length request: done only.
    add(0, 1, 1'b1, 8'd0, 5'b00000);
    add(0, 1, 1'b0, 8'd0, 5'b00001);
    add(0, 2, 1'b0, 8'd0, 5'b00000);
    // Burst B: H=1, idle high, N=2 -> line 1,0,1,0,1.
    add(1, 1, 1'b1, 8'd2, 5'b10000);
    add(1, 1, 1'b0, 8'd0, 5'b01010);
    add(1, 1, 1'b0, 8'd0, 5'b10110);
    add(1, 1, 1'b0, 8'd0, 5'b01010);
    add(1, 1, 1'b0, 8'd0, 5'b10110);
    add(1, 1, 1'b0, 8'd0, 5'b10001);
    add(1, 1, 1'b0, 8'd0, 5'b10000);

    #12;
    chk("reset_a", obs_a, 5'b00000);
    chk("reset_b", obs_b, 5'b10000);
    #4 rst_n = 1'b1;
    tick();
    tick();
    chk("post_reset_a", obs_a, 5'b00000);
    chk("post_reset_b", obs_b, 5'b10000);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int unsigned r = 0; r < vecs[i].reps; r++) begin
        start_a = (vecs[i].dut == 0) ? vecs[i].start : 1'b0;
        num_a   = (vecs[i].dut == 0) ? vecs[i].num   : 8'd0;
        start_b = (vecs[i].dut == 1) ? vecs[i].start : 1'b0;
        num_b   = (vecs[i].dut == 1) ? vecs[i].num   : 8'd0;
        chk($sformatf("vec%0d_rep%0d", i, r), (vecs[i].dut == 0) ? obs_a : obs_b, vecs[i].exp);
        tick();
      end
    end
    start_a = 1'b0; num_a = '0; start_b = 1'b0; num_b = '0;
    tick();

    // Asynchronous reset during ACTIVE: line drops without a clock edge.
    start_a = 1'b1; num_a = 8'd5;
    tick();
    start_a = 1'b0; num_a = '0;
    chk("rst_pre_active", obs_a, 5'b11010);
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_line", obs_a, 5'b00000);
    #2 rst_n = 1'b1;
    done_cnt = 0;
    trail_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done_a) done_cnt++;
      if (trail_a) trail_cnt++;
    end
    chk("rst_no_done_trail", {3'b000, done_cnt[0] | (done_cnt > 1), trail_cnt[0] | (trail_cnt > 1)}, 5'b00000);
    chk("rst_idle_after", obs_a, 5'b00000);

`ifdef EDGE_GEN_ABORT_EN
    // Abort during ACTIVE at T+2.
    start_a = 1'b1; num_a = 8'd5;
    tick();
    start_a = 1'b0; num_a = '0;
    tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("abort_active", obs_a, 5'b00101);
    tick();
    chk("abort_active_after", obs_a, 5'b00000);
    // Abort during REST at T+6.
    start_a = 1'b1; num_a = 8'd5;
    tick();
    start_a = 1'b0; num_a = '0;
    for (int c = 0; c < 5; c++) tick();
    chk("abort_rest_pre", obs_a, 5'b00010);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("abort_rest", obs_a, 5'b00001);
    // Abort while idle is ignored.
    tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("abort_idle", obs_a, 5'b00000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
